// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the UART transmit scheduler and its arbiter.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [3:0] onehot_to_index(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter side bundle of the UART transmit scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  // Requester handshake: a byte moves in any cycle where reqValid[i] & reqReady[i];
  // reqValid may drop before acceptance without consequence. Transmitter side:
  // txStart is a one-cycle launch, txReady low->high marks frame completion.
  logic [NUM_REQ-1:0]            reqValid;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
  logic [NUM_REQ-1:0]            reqLast;
  logic [NUM_REQ-1:0]            reqReady;
  logic [DATA_WIDTH-1:0]         txData;
  logic                          txStart;
  logic                          txReady;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          timeoutErr;

  modport master (
    output reqValid, reqData, reqLast, txReady,
    input  reqReady, txData, txStart, grant, busy, timeoutErr
  );

  modport slave (
    input  reqValid, reqData, reqLast, txReady,
    output reqReady, txData, txStart, grant, busy, timeoutErr
  );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after lastGrant wins.
module rr_priority_arbiter
  import uart_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idxWidth(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] lastGrant,
  output logic [N-1:0]  winnerOh,
  output logic [IW-1:0] winnerIdx,
  output logic          anyValid
);

  always_comb begin
    int idx;
    idx      = 0;
    winnerOh = '0;
    anyValid = 1'b0;
    // k runs to N so lastGrant itself is considered last.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(lastGrant) + k) % N;
      if (!anyValid && req[idx]) begin
        anyValid      = 1'b1;
        winnerOh[idx] = 1'b1;
      end
    end
  end

  assign winnerIdx = IW'(onehot_to_index(16'(winnerOh)));

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-locked sharing of one UART transmitter between requesters.
// Optional watchdog enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_scheduler_if.slave  bus,
  output state_t              dbgState
);

  localparam int IW = idxWidth(NUM_REQ);

  state_t                state;
  logic [IW-1:0]         lastGrant;
  logic                  locked;
  logic [NUM_REQ-1:0]    grantQ;
  logic [DATA_WIDTH-1:0] txDataQ;
  logic                  txStartQ;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    winOh;
  logic [IW-1:0]         winIdx;
  logic                  anyValid;
  logic                  accept;
  logic [DATA_WIDTH-1:0] winData;
  logic                  winLast;

  // While a packet is open only its owner may be chosen.
  assign eligible = locked ? (bus.reqValid & grantQ) : bus.reqValid;

  rr_priority_arbiter #(.N(NUM_REQ), .IW(IW)) uArb (
    .req       (eligible),
    .lastGrant (lastGrant),
    .winnerOh  (winOh),
    .winnerIdx (winIdx),
    .anyValid  (anyValid)
  );

  assign accept  = (state == IDLE) && bus.txReady && anyValid;
  assign winData = bus.reqData[int'(winIdx)*DATA_WIDTH +: DATA_WIDTH];
  assign winLast = bus.reqLast[winIdx];

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int CW = idxWidth(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] waitCnt;
  logic          waitStay;
  logic          timeoutQ;

  assign waitStay = ((state == WAIT_BUSY) &&  bus.txReady) ||
                    ((state == WAIT_DONE) && !bus.txReady);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= IW'(NUM_REQ - 1);
      locked    <= 1'b0;
      grantQ    <= '0;
      txDataQ   <= '0;
      txStartQ  <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      waitCnt   <= '0;
      timeoutQ  <= 1'b0;
`endif
    end else begin
      txStartQ <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            txDataQ   <= winData;
            grantQ    <= winOh;
            lastGrant <= winIdx;
            locked    <= ~winLast;
            txStartQ  <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH:    state <= WAIT_BUSY;
        WAIT_BUSY: if (!bus.txReady) state <= WAIT_DONE;
        WAIT_DONE: begin
          if (bus.txReady) begin
            state <= IDLE;
            if (!locked) grantQ <= '0;
          end
        end
        default:   state <= IDLE;
      endcase
`ifdef UART_SCHED_TIMEOUT_EN
      // Counter only advances while a wait state holds; any transition clears it.
      waitCnt <= waitStay ? waitCnt + 1'b1 : '0;
      if (waitStay && (waitCnt == CW'(TIMEOUT_CYCLES - 1))) begin
        state    <= IDLE;
        timeoutQ <= 1'b1;
        locked   <= 1'b0;
        grantQ   <= '0;
        waitCnt  <= '0;
      end
`endif
    end
  end

  assign bus.reqReady = accept ? winOh : '0;
  assign bus.txData   = txDataQ;
  assign bus.txStart  = txStartQ;
  assign bus.grant    = grantQ;
  assign bus.busy     = (state != IDLE);
`ifdef UART_SCHED_TIMEOUT_EN
  assign bus.timeoutErr = timeoutQ;
`else
  assign bus.timeoutErr = 1'b0;
`endif
  assign dbgState = state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple transmitter model.
module tb_uart_tx_scheduler;
  import uart_sched_pkg::*;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TO_CYCLES = 20;
`else
  localparam int TO_CYCLES = 65535;
`endif

  logic   clk = 1'b0;
  logic   rst;
  state_t dbgState;
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;

  logic   mdlReady = 1'b1;
  int     mdlCnt = 0;
  int     frameLen = 10;
  logic   modelEn = 1'b1;
  logic   holdLow = 1'b0;

  uart_tx_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: txReady low for frameLen cycles starting the cycle after txStart.
  always @(posedge clk) begin
    if (bus.txStart && modelEn) begin
      mdlReady <= 1'b0;
      mdlCnt   <= frameLen - 1;
    end else if (!mdlReady) begin
      if (mdlCnt == 0) mdlReady <= 1'b1;
      else             mdlCnt   <= mdlCnt - 1;
    end
  end
  assign bus.txReady = mdlReady & ~holdLow;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns the first non-zero reqReady seen.
  task automatic wait_accept(input int maxc, output logic [3:0] rr);
    rr = '0;
    for (int i = 0; i < maxc; i++) begin
      #1 rr = bus.reqReady;
      if (rr != 0) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk); #1;
      if (!bus.busy) break;
    end
    chk("idle_reached", 32'(bus.busy), 0);
    @(negedge clk);
  endtask

  logic [3:0] rr;
  int         expOrder[5] = '{0, 1, 2, 3, 0};
  int         prevT, bad;

  initial begin
    rst = 1'b1;
    bus.reqValid = '0;
    bus.reqData  = '0;
    bus.reqLast  = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_reqReady", 32'(bus.reqReady), 0);
    chk("rst_txData", 32'(bus.txData), 0);
    chk("rst_txStart", 32'(bus.txStart), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_timeoutErr", 32'(bus.timeoutErr), 0);
    chk("rst_state", 32'(dbgState), 32'(IDLE));
    @(negedge clk) rst = 1'b0;

    // Single byte with a long frame
    frameLen = 160;
    @(negedge clk);
    bus.reqValid = 4'b0001;
    bus.reqData  = 32'h0000_00A5;
    bus.reqLast  = 4'b0001;
    #1;
    chk("single_reqReady", 32'(bus.reqReady), 1);
    chk("single_busy_T", 32'(bus.busy), 0);
    @(negedge clk);
    bus.reqValid = '0;
    #1;
    chk("single_txStart", 32'(bus.txStart), 1);
    chk("single_txData", 32'(bus.txData), 32'hA5);
    chk("single_grant", 32'(bus.grant), 1);
    chk("single_reqReady_off", 32'(bus.reqReady), 0);
    @(negedge clk); #1;
    chk("single_txStart_off", 32'(bus.txStart), 0);
    chk("single_state_wait", 32'(dbgState), 32'(WAIT_BUSY));
    wait_idle(300);
    chk("single_grant_clr", 32'(bus.grant), 0);
    chk("single_txData_hold", 32'(bus.txData), 32'hA5);

    // Round-robin from a fresh reset
    frameLen = 10;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    bus.reqData  = 32'h1312_1110;
    bus.reqLast  = 4'b1111;
    bus.reqValid = 4'b1111;
    prevT = 0;
    for (int n = 0; n < 5; n++) begin
      wait_accept(40, rr);
      chk("rr_order", 32'(rr), 32'(1 << expOrder[n]));
      if (n > 0) chk("rr_gap", 32'(cyc - prevT), 13);
      prevT = cyc;
      @(negedge clk);
      if (n == 4) bus.reqValid = '0;
      #1;
      chk("rr_txData", 32'(bus.txData), 32'(8'h10 + expOrder[n]));
      @(negedge clk);
    end
    wait_idle(40);

    // Packet lock: req1 sends three bytes while req2 waits
    bus.reqData  = 32'h13C2_B110;
    bus.reqLast  = 4'b0100;
    bus.reqValid = 4'b0110;
    wait_accept(40, rr);
    chk("lock_b1", 32'(rr), 32'b0010);
    @(negedge clk);
    bus.reqData[15:8] = 8'hB2;
    #1;
    chk("lock_b1_data", 32'(bus.txData), 32'hB1);
    chk("lock_grant", 32'(bus.grant), 32'b0010);
    @(negedge clk);
    wait_accept(40, rr);
    chk("lock_b2", 32'(rr), 32'b0010);
    @(negedge clk);
    bus.reqValid[1] = 1'b0;
    #1;
    chk("lock_b2_data", 32'(bus.txData), 32'hB2);
    bad = 0;
    repeat (50) begin
      @(negedge clk); #1;
      if (bus.reqReady != 0) bad++;
    end
    chk("lock_hold_off", 32'(bad), 0);
    chk("lock_grant_held", 32'(bus.grant), 32'b0010);
    chk("lock_idle_wait", 32'(bus.busy), 0);
    @(negedge clk);
    bus.reqData[15:8] = 8'hB3;
    bus.reqLast  = 4'b0110;
    bus.reqValid = 4'b0110;
    wait_accept(40, rr);
    chk("lock_b3", 32'(rr), 32'b0010);
    @(negedge clk);
    bus.reqValid[1] = 1'b0;
    #1;
    chk("lock_b3_data", 32'(bus.txData), 32'hB3);
    @(negedge clk);
    wait_accept(40, rr);
    chk("lock_then_req2", 32'(rr), 32'b0100);
    @(negedge clk);
    bus.reqValid = '0;
    #1;
    chk("lock_req2_data", 32'(bus.txData), 32'hC2);
    chk("lock_req2_grant", 32'(bus.grant), 32'b0100);
    wait_idle(40);
    chk("lock_grant_clr", 32'(bus.grant), 0);

    // Transmitter not ready at request time
    holdLow = 1'b1;
    bus.reqValid = 4'b0001;
    bus.reqData  = 32'h0000_005A;
    bus.reqLast  = 4'b0001;
    bad = 0;
    repeat (5) begin
      #1;
      if (bus.reqReady != 0 || bus.txStart) bad++;
      @(negedge clk);
    end
    chk("notready_hold", 32'(bad), 0);
    holdLow = 1'b0;
    #1;
    chk("notready_release", 32'(bus.reqReady), 32'b0001);
    @(negedge clk);
    bus.reqValid = '0;
    #1;
    chk("notready_txStart", 32'(bus.txStart), 1);
    chk("notready_txData", 32'(bus.txData), 32'h5A);
    wait_idle(40);

    // Asynchronous reset in WAIT_DONE
    bus.reqValid = 4'b1000;
    bus.reqData  = 32'h7700_0000;
    bus.reqLast  = 4'b1000;
    wait_accept(40, rr);
    chk("arst_accept", 32'(rr), 32'b1000);
    @(negedge clk);
    bus.reqValid = '0;
    repeat (4) @(negedge clk);
    #1;
    chk("arst_pre_state", 32'(dbgState), 32'(WAIT_DONE));
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", 32'(bus.grant), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_txData", 32'(bus.txData), 0);
    chk("arst_txStart", 32'(bus.txStart), 0);
    chk("arst_state", 32'(dbgState), 32'(IDLE));
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.txReady) break;
      @(negedge clk);
    end
    chk("arst_tx_ready_back", 32'(bus.txReady), 1);
    @(negedge clk);
    bus.reqData  = 32'h4433_2211;
    bus.reqLast  = 4'b1111;
    bus.reqValid = 4'b1111;
    #1;
    chk("arst_prio_restart", 32'(bus.reqReady), 32'b0001);
    @(negedge clk);
    bus.reqValid = '0;
    #1;
    chk("arst_txData_new", 32'(bus.txData), 32'h11);
    wait_idle(40);

`ifdef UART_SCHED_TIMEOUT_EN
    // Watchdog: transmitter never reacts
    modelEn = 1'b0;
    bus.reqValid = 4'b0001;
    bus.reqLast  = 4'b0001;
    wait_accept(40, rr);
    chk("to_accept", 32'(rr), 32'b0001);
    @(negedge clk);
    bus.reqValid = '0;
    repeat (25) @(negedge clk);
    #1;
    chk("to_err", 32'(bus.timeoutErr), 1);
    chk("to_idle", 32'(bus.busy), 0);
    chk("to_grant", 32'(bus.grant), 0);
    @(negedge clk);
    modelEn = 1'b1;
    bus.reqValid = 4'b0010;
    bus.reqLast  = 4'b0010;
    wait_accept(40, rr);
    chk("to_next_served", 32'(rr), 32'b0010);
    @(negedge clk);
    bus.reqValid = '0;
    wait_idle(40);
    chk("to_err_sticky", 32'(bus.timeoutErr), 1);
`else
    chk("no_timeout_err", 32'(bus.timeoutErr), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one uart_transmitter between NUM_REQ byte-stream requesters using round-robin arbitration with packet lock. A granted requester keeps the transmitter until its byte flagged last has been accepted.
The block sequences the transmitter handshake: it issues a one-cycle txStart with registered txData, then tracks tx_ready falling and rising to detect frame completion.
It sits between the requester clients and the transmitter's dataIn/txStart/tx_ready pins.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, byte width; must match the transmitter
TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
reqValid  input  NUM_REQ  per-requester byte available
reqData  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
reqLast  input  NUM_REQ  byte is the last of the packet
reqReady  output  NUM_REQ  one-hot accept pulse; byte transferred when reqValid[i] & reqReady[i]
txData  output  DATA_WIDTH  to transmitter dataIn
txStart  output  1  to transmitter txStart, one-cycle pulse
txReady  input  1  from transmitter tx_ready
grant  output  NUM_REQ  one-hot current owner; 0 when unowned
busy  output  1  high whenever state is not IDLE
timeoutErr  output  1  sticky watchdog flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, active-high):
  - State IDLE.
  - reqReady=0, txData=0, txStart=0, grant=0, busy=0, timeoutErr=0.
  - lastGrant=NUM_REQ-1, so requester 0 has first priority.
  - locked=0.
- Reset asserted mid-frame aborts the sequence immediately. The transmitter is reset separately.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE, cycle T:
  - If locked: the eligible set is the owner only.
  - Otherwise: the eligible set is all reqValid, searched from lastGrant+1 with modulo-NUM_REQ wrap.
  - If txReady=1 and the eligible set is non-empty:
    - reqReady[winner]=1 combinationally in cycle T.
    - txData<=reqData[winner].
    - grant<=onehot(winner), lastGrant<=winner.
    - locked<=~reqLast[winner].
    - Next state LAUNCH.
  - If txReady=0 in IDLE: no grant is issued.
- LAUNCH, cycle T+1:
  - txStart=1 for exactly this cycle; txData stable.
  - Next state WAIT_BUSY.
  - Latency from reqValid sampled to txStart is 1 cycle.
- WAIT_BUSY: stay until txReady=0 (nominally T+2), then go to WAIT_DONE.
- WAIT_DONE: stay until txReady=1, then go to IDLE.
  - If not locked: grant<=0.
  - Arbitration may occur in the first IDLE cycle.
  - Back-to-back bytes therefore spend 1 IDLE cycle between frames.
- txData holds its value until the next accept.
- reqReady is never asserted outside IDLE and never to more than one requester.
- Packet lock:
  - While locked, other requesters are ignored even if the owner drops reqValid. The scheduler waits in IDLE.
  - Lock clears only on acceptance of a byte with reqLast=1.
  - A single byte with reqLast=1 never locks.
- Simultaneous reqValid from all requesters: each is served in turn 0,1,2,3,0...
- A requester that deasserts reqValid before acceptance loses nothing; no byte is transferred.
- Wrap: the lastGrant+1 search wraps from NUM_REQ-1 to 0.

Optional Feature:
UART_SCHED_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_BUSY and WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES, go to IDLE, set timeoutErr=1 (sticky until rst), and clear locked and grant.
  - The counter clears on every state change.
- Undefined: no counter; timeoutErr tied 0; WAIT states may wait indefinitely.

Decomposition:
- Package uart_sched_pkg:
  - state_t enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
  - Function onehot_to_index.
  - Localparam IDX_WIDTH = $clog2(NUM_REQ) supplied as a parameterised function.
- Sub-module rr_priority_arbiter, combinational:
  - Inputs: request vector, lastGrant index.
  - Outputs: one-hot winner, winner index, anyValid.
  - Reused elsewhere for bus masters.

Test Plan:
- Single byte: reqValid[0]=1, reqData=8'hA5, reqLast=1, txReady=1 → reqReady[0] pulses in cycle T, txStart=1 only in T+1 with txData=8'hA5. Model transmitter (tx_ready low from T+2 for 160 cycles) → returns to IDLE, grant=0.
- Round-robin: all four requesters valid, reqLast=1 each → accept order 0,1,2,3,0. Exactly one reqReady per frame; 1 IDLE cycle between frames.
- Packet lock: req1 sends 3 bytes (reqLast on the 3rd) while req2 holds reqValid → bytes 1,1,1 then 2. Req1 drops reqValid 50 cycles between bytes 2 and 3 → req2 still waits.
- txReady=0 at request time → no reqReady and no txStart until txReady=1.
- Reset mid-WAIT_DONE with rst asserted asynchronously → all outputs 0 immediately. After release, priority restarts at requester 0.
- With UART_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=20, model holds txReady=1 after txStart → after 20 cycles in WAIT_BUSY: timeoutErr=1 and state IDLE. Next request is still served.
